// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct constants shared with the control FSM and the fetch state encoding.
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b110000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_NOP   = 6'b111111;
  localparam logic [5:0] OP_STALL = 6'b000110;
  localparam logic [5:0] FN_JR    = 6'b001000;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_RESOLVE, S_HALT} fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory request/valid bus.
interface instr_fetch_unit_if #(parameter int AW = 32);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          imem_valid;
  modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// next_pc_calc: combinational next-PC selection (J > JR > taken branch > PC+4).
module next_pc_calc import cpu_pkg::*; #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] pc,
  input  logic [31:0]   ir,
  input  logic          beq,
  input  logic          bne,
  input  logic          j,
  input  logic          z,
  input  logic [AW-1:0] jr_target,
  output logic [AW-1:0] next_pc
);
  logic [AW-1:0] pc4, boff;
  logic is_jr, taken;
  always_comb begin
    pc4 = pc + AW'(4);
    boff = {{(AW-18){ir[15]}}, ir[15:0], 2'b00};
    is_jr = (ir[31:26] == OP_RTYPE) && (ir[5:0] == FN_JR);
    taken = (beq & z) | (bne & ~z);
    next_pc = j ? {pc4[AW-1:28], ir[25:0], 2'b00} :
              is_jr ? {jr_target[AW-1:2], 2'b00} :
              taken ? pc4 + boff : pc4;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instruction words, issues decoded fields and resolves the next PC.
module instr_fetch_unit import cpu_pkg::*; #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic                Beq,
  input  logic                Bne,
  input  logic                J,
  input  logic                Z,
  input  logic [AW-1:0]       jr_target,
  input  logic                stall,
  output logic                instr_valid,
  output logic [5:0]          opcode,
  output logic [5:0]          funct,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [4:0]          shamt,
  output logic [15:0]         imm16,
  output logic [AW-1:0]       pc_out,
  output logic                fault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  fetch_state_e state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, addr_q, addr_d, pc_out_q, pc_out_d, npc;
  logic [31:0] ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fault_q, fault_d, extra_q, extra_d;

  next_pc_calc #(.AW(AW)) u_next_pc (
    .pc(pc_q), .ir(ir_q), .beq(Beq), .bne(Bne), .j(J), .z(Z),
    .jr_target(jr_target), .next_pc(npc)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      pc_out_q <= RESET_PC;
      ir_q     <= '0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
      extra_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      pc_out_q <= pc_out_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      extra_q  <= extra_d;
    end

  // The stall opcode costs one extra RESOLVE cycle, tracked by extra_q.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    pc_out_d = pc_out_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    extra_d  = extra_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT:
        if (imem.imem_valid) begin
          ir_d     = imem.imem_rdata;
          pc_out_d = pc_q;
          state_d  = S_ISSUE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else cnt_d = cnt_q + 1'b1;
      S_ISSUE: begin
        state_d = S_RESOLVE;
        extra_d = ir_q[31:26] == OP_STALL;
      end
      S_RESOLVE:
        if (!stall) begin
          if (extra_q) extra_d = 1'b0;
          else begin
            pc_d    = npc;
            addr_d  = npc;
            state_d = S_FETCH;
          end
        end
      default: ;
    endcase
  end

  always_comb begin
    imem.imem_req = state_q == S_FETCH;
    instr_valid   = state_q == S_ISSUE;
  end

  assign imem.imem_addr = addr_q;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm16  = ir_q[15:0];
  assign pc_out = pc_out_q;
  assign fault  = fault_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random fetch sequences against an arithmetic next-PC model.
module tb_instr_fetch_unit;
  logic clk = 1'b0, rst = 1'b0;
  logic Beq = 0, Bne = 0, J = 0, Z = 0, stall = 0;
  logic [31:0] jr_target = 0;
  logic instr_valid, fault;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [31:0] pc_out;
  logic [31:0] exp_pc = 0;
  logic [31:0] w;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [5:0] ops [11] = '{6'h00, 6'h08, 6'h0c, 6'h04, 6'h05, 6'h02, 6'h03, 6'h30, 6'h2b, 6'h3f, 6'h06};

  instr_fetch_unit_if #(.AW(32)) imem ();

  instr_fetch_unit #(.AW(32), .RESET_PC(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .imem(imem), .Beq(Beq), .Bne(Bne), .J(J), .Z(Z),
    .jr_target(jr_target), .stall(stall), .instr_valid(instr_valid),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm16(imm16), .pc_out(pc_out), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] iw,
      input logic b_eq, input logic b_ne, input logic jj, input logic zz, input logic [31:0] jrt);
    logic [31:0] seq;
    int off;
    seq = pc + 32'd4;
    off = $signed(iw[15:0]);
    if (jj) return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 4);
    if (iw[31:26] == 6'd0 && iw[5:0] == 6'd8) return jrt & ~32'd3;
    if ((b_eq && zz) || (b_ne && !zz)) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic wait_req(input int exp_g);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
      stall = 0;
      imem.imem_valid = 0;
    end while (!imem.imem_req && g < 40);
    chk("fetch_gap", g, exp_g);
  endtask

  // Entered at a negedge where a fetch request is expected; leaves at the next one.
  task automatic fetch_one(input logic [31:0] iw, input int lat, input logic b_eq, input logic b_ne,
      input logic jj, input logic zz, input logic [31:0] jrt, input int stl);
    chk("req", imem.imem_req, 1);
    chk("addr", imem.imem_addr, exp_pc);
    @(negedge clk);
    for (int i = 0; i < lat; i++) begin
      chk("wait_idle", {imem.imem_req, instr_valid}, 0);
      @(negedge clk);
    end
    imem.imem_valid = 1;
    imem.imem_rdata = iw;
    @(negedge clk);
    imem.imem_valid = 0;
    imem.imem_rdata = $urandom;
    chk("instr_valid", instr_valid, 1);
    chk("opcode", opcode, iw[31:26]);
    chk("rs_rt_rd_sh", {rs, rt, rd, shamt}, iw[25:6]);
    chk("funct", funct, iw[5:0]);
    chk("imm16", imm16, iw[15:0]);
    chk("pc_out", pc_out, exp_pc);
    Beq = b_eq; Bne = b_ne; J = jj; Z = zz; jr_target = jrt;
    stall = stl > 0;
    for (int i = 0; i < stl; i++) begin
      @(negedge clk);
      chk("stall_idle", {imem.imem_req, instr_valid}, 0);
      chk("ir_hold", {opcode, imm16}, {iw[31:26], iw[15:0]});
      imem.imem_valid = 1;
      imem.imem_rdata = $urandom;
    end
    exp_pc = model_npc(exp_pc, iw, b_eq, b_ne, jj, zz, jrt);
    wait_req(iw[31:26] == 6'b000110 ? 3 : 2);
  endtask

  initial begin
    imem.imem_valid = 0;
    imem.imem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", imem.imem_req, 0);
    chk("rst_addr", imem.imem_addr, 0);
    chk("rst_ivalid", instr_valid, 0);
    chk("rst_fields", {opcode, rs, rt, rd, shamt, funct}, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_fault", fault, 0);
    rst = 1;
    wait_req(1);
    repeat (4) fetch_one(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    fetch_one(32'h1000_FFFE, 0, 1, 0, 0, 1, 0, 0);
    chk("beq_taken", exp_pc, 32'h0C);
    fetch_one(32'h1000_FFFE, 0, 1, 0, 0, 0, 0, 0);
    fetch_one(32'h1000_FFFE, 0, 1, 0, 0, 0, 0, 0);
    chk("beq_not_taken", imem.imem_addr, 32'h14);
    fetch_one(32'h1400_0003, 1, 0, 1, 0, 0, 0, 0);
    fetch_one(32'h0000_0008, 0, 0, 0, 0, 0, 32'h4000_0000, 0);
    fetch_one(32'h0800_0100, 0, 0, 0, 1, 0, 0, 0);
    chk("jump", imem.imem_addr, 32'h4000_0400);
    fetch_one(32'h0060_0008, 2, 0, 0, 0, 0, 32'h123, 0);
    chk("jr", imem.imem_addr, 32'h120);
    fetch_one(32'h8C22_0004, 5, 0, 0, 0, 0, 0, 3);
    fetch_one(32'h1800_0000, 0, 0, 0, 0, 0, 0, 0);
    fetch_one(32'hFC00_0000, 3, 0, 0, 0, 0, 0, 1);
    fetch_one(32'h0000_0008, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
    fetch_one(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap", imem.imem_addr, 32'h0);
    fetch_one(32'h1000_FFFE, 0, 1, 0, 0, 1, 0, 0);
    chk("branch_wrap", imem.imem_addr, 32'hFFFF_FFFC);
    for (int k = 0; k < 40; k++) begin
      w = {ops[$urandom_range(0, 10)], 26'($urandom)};
      if (w[31:26] == 6'd0 && $urandom_range(0, 1) == 1) w[5:0] = 6'b001000;
      fetch_one(w, $urandom_range(0, 6), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 7) == 0, 1'($urandom), $urandom, $urandom_range(0, 2));
    end
    @(negedge clk);
    chk("mid_wait_req", imem.imem_req, 0);
    rst = 0;
    #1;
    chk("async_rst_fields", {opcode, rs, rt, rd, shamt, funct}, 0);
    chk("async_rst_pc_out", pc_out, 0);
    chk("async_rst_addr", imem.imem_addr, 0);
    @(negedge clk);
    rst = 1;
    imem.imem_valid = 1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem.imem_valid = 0;
    chk("late_resp_ignored", {opcode, imm16}, 0);
    Beq = 0; Bne = 0; J = 0;
    exp_pc = 0;
    fetch_one(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("timeout_wait", {imem.imem_req, fault}, 0);
    end
    @(negedge clk);
    chk("timeout_fault", fault, 1);
    for (int i = 0; i < 8; i++) begin
      imem.imem_valid = 1'($urandom);
      imem.imem_rdata = $urandom;
      @(negedge clk);
      chk("halt_idle", {imem.imem_req, instr_valid, fault}, 3'b001);
      chk("halt_ir", funct, 6'h20);
    end
    rst = 0;
    #1;
    chk("fault_cleared", fault, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and sequencing unit that feeds the control FSM. It fetches 32-bit MIPS-format words from instruction memory over a request/valid handshake and presents the decoded fields (opcode, funct, register and immediate fields) with a one-cycle `instr_valid` strobe. It then samples the control FSM's registered Beq/Bne/J outputs and the ALU Z flag to compute the next PC. It is the producer of the instruction fields that the control FSM consumes, and the consumer of its branch/jump decisions.

## Interface
- `AW`, 32: PC / instruction address width.
- `RESET_PC`, 0: PC value loaded on reset.
- `TIMEOUT`, 16: maximum WAIT cycles before a fetch fault.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  one-cycle fetch request.
- `imem_addr`  out  AW  fetch address, valid with `imem_req`.
- `imem_rdata`  in  32  instruction word, valid with `imem_valid`.
- `imem_valid`  in  1  read data valid.
- `Beq`, `Bne`, `J`  in  1 each  registered control FSM outputs.
- `Z`  in  1  ALU zero flag.
- `jr_target`  in  AW  rs register value, used for JR.
- `stall`  in  1  holds the unit in RESOLVE.
- `instr_valid`  out  1  instruction fields valid, one cycle per instruction.
- `opcode`, `funct`  out  6 each  IR[31:26], IR[5:0].
- `rs`, `rt`, `rd`, `shamt`  out  5 each  IR[25:21], IR[20:16], IR[15:11], IR[10:6].
- `imm16`  out  16  IR[15:0].
- `pc_out`  out  AW  address of the instruction currently held in IR.
- `fault`  out  1  sticky fetch-timeout flag.

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, RESOLVE, HALT.
- **IDLE:** entered on reset. Moves to FETCH on the first clock after reset is released.
- **FETCH:** drive `imem_req`=1 and `imem_addr`=PC for exactly one cycle, then go to WAIT. Clear the timeout counter.
- **WAIT:** `imem_req`=0.
  - On `imem_valid`: latch `imem_rdata` into IR, set `pc_out`=PC, go to ISSUE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without `imem_valid`, set `fault`=1 and go to HALT.
- **ISSUE:** `instr_valid`=1 for this single cycle, then go to RESOLVE.
- **RESOLVE:** control inputs are sampled here (the control FSM registers its outputs at the edge that ends ISSUE).
  - If `stall`=1, stay in RESOLVE and resample every cycle.
  - Otherwise load the next PC and go to FETCH.
- Next-PC priority, with pc4 = PC+4:
  1. `J`=1: {pc4[AW-1:28], IR[25:0], 2'b00}.
  2. JR (opcode 000000, funct 001000): `jr_target` with bits [1:0] forced to 0.
  3. (`Beq`&`Z`)|(`Bne`&~`Z`): pc4 + (sign-extended `imm16` << 2).
  4. Otherwise pc4.
- NOP (opcode 111111) and stall opcode (000110) take the sequential PC. For opcode 000110 the unit inserts one extra RESOLVE cycle before FETCH.
- **HALT:** terminal. Only reset exits. `imem_req`=0, `instr_valid`=0.
- `imem_valid` outside WAIT is ignored; IR is not modified.
- PC arithmetic is modulo 2^AW: 0xFFFFFFFC + 4 wraps to 0x00000000. Branch offsets wrap the same way.

## Timing
- Reset values: state=IDLE, PC=`RESET_PC`, IR=0 (all field outputs 0), `pc_out`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `fault`=0, counter=0.
- Reset asserted mid-operation clears everything immediately. A response arriving after reset release is ignored because the unit is not in WAIT.
- Zero-wait memory (`imem_valid` in the first WAIT cycle) gives one instruction every 4 cycles: FETCH, WAIT, ISSUE, RESOLVE.
- IR fields hold stable from ISSUE until the next WAIT capture.
- `imem_addr` is registered and updates only on entry to FETCH.

## Structure
- `cpu_pkg`: opcode constants (RTYPE 000000, ADDI 001000, ANDI 001100, BEQ 000100, BNE 000101, J 000010, JAL 000011, LW 110000, SW 101011, NOP 111111, STALL 000110), funct JR 001000, and the fetch state enum. These constants are shared with the control FSM.
- Sub-module `next_pc_calc`: purely combinational; inputs PC, IR, Beq/Bne/J/Z, jr_target; output next PC.

## Test plan
- **Sequential fetch.** Reset with RESET_PC=0, memory returns 0x00000020 (add) with zero wait. Required: `imem_addr` sequence 0x0, 0x4, 0x8; `instr_valid` every 4th cycle; funct=100000.
- **Taken branch.** PC=0x10, IR=0x1000FFFE (beq, imm=-2), `Beq`=1, `Z`=1. Required: next `imem_addr`=0x0C. The same case with `Z`=0 gives 0x14.
- **Jump.** PC=0x40000000, IR=0x08000100. Required: next `imem_addr`=0x40000400. JR with `jr_target`=0x123 gives 0x120.
- **Stall and delayed memory.** Hold `stall`=1 for 3 RESOLVE cycles, and delay `imem_valid` by 5 cycles. Required: no `imem_req` during the stall; exactly one `instr_valid` per fetched word.
- **Timeout.** `imem_valid` never asserts. Required: `fault`=1 after 16 WAIT cycles, then state HALT with `imem_req` held at 0 until reset.
- **Wrap and reset.** PC=0xFFFFFFFC sequential gives 0x0. Assert `rst` in WAIT and return `imem_valid` afterward. Required: IR stays 0, then fetch restarts at RESET_PC.
